// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int DIV_RST_DEFAULT = 127;

  typedef struct packed {
    logic div_out;
    logic tick;
    logic pend;
  } ch_out_t;

  // Index width that never collapses to zero bits for a single channel
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrap counter, double-buffered divisor, toggle output and tick.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = DIV_RST_DEFAULT
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic         sync_clr,
  input  logic         wr,
  input  logic [W-1:0] wdiv,
  output ch_out_t      st
);

  localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

  logic [W-1:0] cnt, div_cur, div_nxt;
  logic         pend, dout, tck;

  // wr is only ever raised while pend is clear, so it never races an apply
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt     <= '0;
      div_cur <= DEF;
      div_nxt <= DEF;
      pend    <= 1'b0;
      dout    <= 1'b0;
      tck     <= 1'b0;
    end else begin
      tck <= 1'b0;
      if (sync_clr) begin
        cnt  <= '0;
        dout <= 1'b0;
        if (pend) begin
          div_cur <= div_nxt;
          pend    <= 1'b0;
        end
      end else begin
        if (wr) begin
          div_nxt <= wdiv;
          pend    <= 1'b1;
        end
        if (en) begin
          if (cnt == div_cur) begin
            cnt  <= '0;
            dout <= ~dout;
            tck  <= 1'b1;
            if (pend) begin
              div_cur <= div_nxt;
              pend    <= 1'b0;
            end
          end else begin
            cnt <= cnt + W'(1);
          end
        end else if (pend) begin
          // idle channel has no period to protect: take the new divisor now
          div_cur <= div_nxt;
          pend    <= 1'b0;
          cnt     <= '0;
        end
      end
    end
  end

  assign st.div_out = dout;
  assign st.tick    = tck;
  assign st.pend    = pend;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NCH programmable clock dividers: config decode, ready mux and group realign fan-out.
module multi_channel_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int  NCH         = 4,
  parameter int  W           = 16,
  parameter int  DEFAULT_DIV = DIV_RST_DEFAULT,
  localparam int CHW         = chw(NCH)
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic [NCH-1:0] en,
  input  logic           sync_clr,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  output logic [NCH-1:0] div_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pend
);

  localparam int NSLOT = 2**CHW;

  ch_out_t [NCH-1:0]   st;
  logic    [NSLOT-1:0] pend_pad;
  logic                acc;

  // unused index slots read as not-pending so writes to them are accepted and dropped
  assign cfg_ready = ~pend_pad[cfg_ch];
  assign acc       = cfg_valid & cfg_ready & ~sync_clr;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkdiv_channel #(
      .W          (W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .arst_n  (arst_n),
      .en      (en[i]),
      .sync_clr(sync_clr),
      .wr      (acc && (cfg_ch == CHW'(i))),
      .wdiv    (cfg_div),
      .st      (st[i])
    );
    assign div_out[i] = st[i].div_out;
    assign tick[i]    = st[i].tick;
    assign pend[i]    = st[i].pend;
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_pad
    if (i < NCH) begin : g_in
      assign pend_pad[i] = st[i].pend;
    end else begin : g_out
      assign pend_pad[i] = 1'b0;
    end
  end

endmodule
